// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/memory types and arbiter encodings
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational winner selection, rotating from ptr or fixed from index 0
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   input  logic            mode,
   output logic [IW-1:0]   idx,
   output logic            any
);
   logic [IW-1:0] base;
   assign base = mode ? '0 : ptr;
   assign any  = |req;
   // scan from the farthest offset to the nearest so the nearest requester from base wins
   always_comb begin
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (|(req & (NREQ'(1) << ((int'(base) + k) % NREQ)))) idx = IW'((int'(base) + k) % NREQ);
   end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: arbitrates NREQ read/write requesters onto a single RAM port
module mem_arbiter_rr
   import cpu_types_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int MODE = MODE_RR,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic   [NREQ-1:0]   REN,
   input  logic   [NREQ-1:0]   WEN,
   input  word_t  [NREQ-1:0]   addr,
   input  word_t  [NREQ-1:0]   store,
   output logic   [NREQ-1:0]   rwait,
   output word_t  [NREQ-1:0]   load,
   input  ramstate_t           ramstate,
   input  word_t               ramload,
   output word_t               ramaddr,
   output word_t               ramstore,
   output logic                ramREN,
   output logic                ramWEN,
   output logic   [IW-1:0]     gnt_id,
   output logic                gnt_vld
);
   arb_state_t      state;
   logic [IW-1:0]   rr_ptr, pick_idx;
   logic            pick_any, held, done;
   logic [NREQ-1:0] req;

   assign req  = REN | WEN;
   assign held = gnt_vld & req[gnt_id];
   assign done = held & (ramstate == ACCESS) & ~RST;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (req),
      .ptr  (rr_ptr),
      .mode (MODE == MODE_FIXED),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // grant in IDLE; leave GRANT on completion or when the owner withdraws its request
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         gnt_id  <= '0;
         gnt_vld <= 1'b0;
      end else if (state == IDLE) begin
         if (pick_any) begin
            state   <= GRANT;
            gnt_id  <= pick_idx;
            gnt_vld <= 1'b1;
         end
      end else if (done || !req[gnt_id]) begin
         state   <= IDLE;
         gnt_vld <= 1'b0;
         if (done) rr_ptr <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   assign ramaddr  = gnt_vld ? addr[gnt_id] : '0;
   assign ramstore = gnt_vld ? store[gnt_id] : '0;
   assign ramWEN   = held & WEN[gnt_id];
   assign ramREN   = held & REN[gnt_id] & ~WEN[gnt_id];

   for (genvar i = 0; i < NREQ; i++) begin : g_ch
      logic hit;
      assign hit      = done && (gnt_id == IW'(i));
      assign rwait[i] = req[i] & ~hit;
      assign load[i]  = hit ? ramload : '0;
   end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: scoreboard bench with a transaction-level arbiter model
module tb_mem_arbiter_rr;
   import cpu_types_pkg::*;
   localparam int N  = 4;
   localparam int IW = $clog2(N);

   typedef struct {int d; int ch; word_t data;} comp_t;

   logic CLK = 1'b0;
   logic RST;
   logic [N-1:0] ren [2], wen [2], rwait [2];
   word_t [N-1:0] addr [2], store [2], load [2];
   ramstate_t ramstate;
   word_t ramload;
   word_t ramaddr [2], ramstore [2];
   logic ramren [2], ramwen [2], gnt_vld [2];
   logic [IW-1:0] gnt_id [2];

   int m_own [2], m_ptr [2], n_own [2], n_ptr [2], e_id [2];
   bit e_vld [2], e_ren [2], e_wen [2], e_done [2];
   word_t e_addr [2], e_store [2];
   comp_t sbq [$];
   int log_ch [$], log_cyc [$], fp_ch [$];
   int cyc = 0, n_chk = 0, n_err = 0, c0;

   always #5 CLK = ~CLK;

   mem_arbiter_rr #(.NREQ(N), .MODE(MODE_RR)) u_rr (
      .CLK(CLK), .RST(RST), .REN(ren[0]), .WEN(wen[0]), .addr(addr[0]), .store(store[0]),
      .rwait(rwait[0]), .load(load[0]), .ramstate(ramstate), .ramload(ramload),
      .ramaddr(ramaddr[0]), .ramstore(ramstore[0]), .ramREN(ramren[0]), .ramWEN(ramwen[0]),
      .gnt_id(gnt_id[0]), .gnt_vld(gnt_vld[0])
   );

   mem_arbiter_rr #(.NREQ(N), .MODE(MODE_FIXED)) u_fp (
      .CLK(CLK), .RST(RST), .REN(ren[1]), .WEN(wen[1]), .addr(addr[1]), .store(store[1]),
      .rwait(rwait[1]), .load(load[1]), .ramstate(ramstate), .ramload(ramload),
      .ramaddr(ramaddr[1]), .ramstore(ramstore[1]), .ramREN(ramren[1]), .ramWEN(ramwen[1]),
      .gnt_id(gnt_id[1]), .gnt_vld(gnt_vld[1])
   );

   task automatic chk(string nm, longint act, longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit bit_of(logic [N-1:0] v, int j);
      return (j >= 0) && (|(v & (N'(1) << j)));
   endfunction

   // instance 0 searches from its pointer, instance 1 always from channel 0
   function automatic int pick(int d, logic [N-1:0] req);
      int base = (d == 1) ? 0 : m_ptr[d];
      for (int k = 0; k < N; k++) if (bit_of(req, (base + k) % N)) return (base + k) % N;
      return -1;
   endfunction

   // expected behaviour for the cycle whose inputs are currently driven
   task automatic eval(int d);
      logic [N-1:0] req = ren[d] | wen[d];
      int o = m_own[d];
      logic [IW-1:0] oi = IW'(o);
      bit live = (o >= 0) && bit_of(req, o);
      e_vld[d]   = o >= 0;
      e_id[d]    = o;
      e_wen[d]   = live && bit_of(wen[d], o);
      e_ren[d]   = live && bit_of(ren[d], o) && !bit_of(wen[d], o);
      e_addr[d]  = (o >= 0) ? addr[d][oi] : '0;
      e_store[d] = (o >= 0) ? store[d][oi] : '0;
      e_done[d]  = live && ramstate == ACCESS && !RST;
      if (e_done[d]) sbq.push_back(comp_t'{d, o, ramload});
      n_ptr[d] = RST ? 0 : e_done[d] ? (o + 1) % N : m_ptr[d];
      n_own[d] = RST ? -1 : (o < 0) ? pick(d, req) : (live && !e_done[d]) ? o : -1;
   endtask

   task automatic tick();
      for (int d = 0; d < 2; d++) eval(d);
      @(posedge CLK);
      for (int d = 0; d < 2; d++) begin
         m_own[d] = n_own[d];
         m_ptr[d] = n_ptr[d];
      end
      cyc++;
      #1;
   endtask

   task automatic clr();
      for (int d = 0; d < 2; d++) begin
         ren[d] = '0;
         wen[d] = '0;
      end
   endtask

   task automatic mon(int d);
      logic [N-1:0] req = ren[d] | wen[d];
      int seen = -1;
      for (int i = 0; i < N; i++) if (bit_of(req, i) && !bit_of(rwait[d], i)) seen = i;
      if (seen >= 0) begin
         if (d == 0) begin
            log_ch.push_back(seen);
            log_cyc.push_back(cyc);
         end else fp_ch.push_back(seen);
      end
      if (sbq.size() > 0 && sbq[0].d == d) begin
         chk("done_ch", seen, sbq[0].ch);
         if (seen >= 0) chk("done_load", load[d][IW'(seen)], sbq[0].data);
         void'(sbq.pop_front());
      end else chk("spurious_done", seen, -1);
      chk("gnt_vld", gnt_vld[d], e_vld[d]);
      if (e_vld[d]) chk("gnt_id", gnt_id[d], e_id[d]);
      chk("ramREN", ramren[d], e_ren[d]);
      chk("ramWEN", ramwen[d], e_wen[d]);
      chk("ramaddr", ramaddr[d], e_addr[d]);
      chk("ramstore", ramstore[d], e_store[d]);
      for (int i = 0; i < N; i++) begin
         bit hit = e_done[d] && e_id[d] == i;
         chk("rwait", rwait[d][IW'(i)], bit_of(req, i) && !hit);
         chk("load", load[d][IW'(i)], hit ? ramload : 32'h0);
      end
   endtask

   always @(negedge CLK) for (int d = 0; d < 2; d++) mon(d);

   // random requesters: hold until completion, occasionally abort while granted
   task automatic rand_drive(int d);
      for (int i = 0; i < N; i++) begin
         logic [IW-1:0] ii = IW'(i);
         logic [1:0] r;
         bit pend = bit_of(ren[d] | wen[d], i);
         bit fin = e_done[d] && e_id[d] == i;
         if (fin || !pend) begin
            r = 2'($urandom_range(3));
            if ($urandom_range(2) == 0) r = 2'b00;
            ren[d][ii] = r[0];
            wen[d][ii] = r[1];
            addr[d][ii] = $urandom;
            store[d][ii] = $urandom;
         end else if (e_vld[d] && e_id[d] == i && !e_done[d] && $urandom_range(15) == 0) begin
            ren[d][ii] = 1'b0;
            wen[d][ii] = 1'b0;
         end
      end
   endtask

   initial begin
      int r;
      for (int d = 0; d < 2; d++) begin
         m_own[d] = -1;
         m_ptr[d] = 0;
         for (int i = 0; i < N; i++) begin
            addr[d][IW'(i)] = $urandom;
            store[d][IW'(i)] = $urandom;
         end
      end
      clr();
      RST = 1'b1;
      ramstate = FREE;
      ramload = '0;
      tick();
      tick();
      chk("rst_vld0", gnt_vld[0], 0);
      chk("rst_vld1", gnt_vld[1], 0);
      RST = 1'b0;

      log_ch.delete(); log_cyc.delete(); fp_ch.delete();
      ren[0] = 4'hF;
      ren[1] = 4'b1010;
      ramstate = ACCESS;
      for (int k = 0; k < 10; k++) begin
         ramload = $urandom;
         tick();
      end
      chk("rr_count", log_ch.size(), 5);
      for (int k = 0; k < log_ch.size() && k < 5; k++) chk("rr_order", log_ch[k], k % 4);
      for (int k = 1; k < log_cyc.size(); k++) chk("rr_spacing", log_cyc[k] - log_cyc[k-1], 2);
      chk("fp_count", fp_ch.size(), 5);
      for (int k = 0; k < fp_ch.size(); k++) chk("fp_winner", fp_ch[k], 1);
      chk("fp_wait3", rwait[1][3], 1);
      clr();
      ramstate = FREE;
      tick();

      log_ch.delete(); log_cyc.delete();
      c0 = cyc;
      ren[0][2] = 1'b1;
      addr[0][2] = 32'h40;
      tick();
      ramstate = BUSY;
      tick();
      tick();
      ramstate = ACCESS;
      ramload = 32'hDEADBEEF;
      tick();
      clr();
      ramstate = FREE;
      tick();
      chk("rd_count", log_ch.size(), 1);
      if (log_ch.size() > 0) begin
         chk("rd_ch", log_ch[0], 2);
         chk("rd_cycle", log_cyc[0] - c0, 3);
      end

      log_ch.delete(); log_cyc.delete();
      c0 = cyc;
      ren[0][0] = 1'b1;
      wen[0][0] = 1'b1;
      addr[0][0] = 32'h80;
      store[0][0] = 32'h1234;
      tick();
      ramstate = ERROR;
      tick();
      ramstate = ACCESS;
      ramload = 32'h5555AAAA;
      tick();
      clr();
      ramstate = FREE;
      tick();
      chk("wr_count", log_ch.size(), 1);
      if (log_ch.size() > 0) begin
         chk("wr_ch", log_ch[0], 0);
         chk("wr_cycle", log_cyc[0] - c0, 2);
      end

      log_ch.delete(); log_cyc.delete();
      ren[0][3] = 1'b1;
      ramstate = BUSY;
      tick();
      tick();
      clr();
      tick();
      tick();
      chk("abort_count", log_ch.size(), 0);
      ren[0] = 4'b1101;
      ramstate = ACCESS;
      tick();
      tick();
      clr();
      ramstate = FREE;
      tick();
      chk("ptr_kept_count", log_ch.size(), 1);
      if (log_ch.size() > 0) chk("ptr_kept_ch", log_ch[0], 2);

      log_ch.delete(); log_cyc.delete();
      ren[0][1] = 1'b1;
      ramstate = BUSY;
      tick();
      tick();
      RST = 1'b1;
      tick();
      chk("midrst_vld", gnt_vld[0], 0);
      chk("midrst_ren", ramren[0], 0);
      RST = 1'b0;
      ren[0] = 4'hF;
      ramstate = ACCESS;
      tick();
      tick();
      clr();
      tick();
      chk("midrst_count", log_ch.size(), 1);
      if (log_ch.size() > 0) chk("midrst_first", log_ch[0], 0);

      for (int t = 0; t < 800; t++) begin
         RST = ($urandom_range(149) == 0);
         r = $urandom_range(9);
         ramstate = (r < 4) ? ACCESS : (r < 6) ? BUSY : (r < 8) ? FREE : ERROR;
         ramload = $urandom;
         rand_drive(0);
         rand_drive(1);
         tick();
      end
      RST = 1'b0;
      clr();
      tick();
      chk("sb_drain", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter NREQ, default 4, number of requester channels (core0 I, core0 D, core1 I, core1 D); legal range 2..8.
REQ-002 Parameter MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-005 REN  input  NREQ  per-channel read request, held level until that channel's wait drops.
REQ-006 WEN  input  NREQ  per-channel write request, held level until that channel's wait drops.
REQ-007 addr  input  NREQ x word_t  per-channel address.
REQ-008 store  input  NREQ x word_t  per-channel write data.
REQ-009 rwait  output  NREQ  per-channel wait; 0 means the channel's access completes this cycle.
REQ-010 load  output  NREQ x word_t  per-channel read data, valid only in the completion cycle.
REQ-011 ramstate  input  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR.
REQ-012 ramload  input  word_t  RAM read data.
REQ-013 ramaddr, ramstore  output  word_t  RAM address and write data.
REQ-014 ramREN, ramWEN  output  1  RAM read and write strobes.
REQ-015 gnt_id  output  $clog2(NREQ)  index of the granted channel; valid while gnt_vld=1.
REQ-016 gnt_vld  output  1  a grant is held.

Function
REQ-017 FSM states: IDLE and GRANT.
REQ-018 In IDLE, if any channel has REN|WEN, the block selects a winner by MODE, registers it into gnt_id, and enters GRANT on the next edge.
REQ-019 Round-robin: search starts at rr_ptr and wraps modulo NREQ; the first requesting channel wins.
REQ-020 On completion, rr_ptr becomes (gnt_id+1) mod NREQ; rr_ptr is not updated on abort.
REQ-021 In GRANT, ramaddr and ramstore follow the granted channel.
REQ-022 In GRANT, ramWEN = granted WEN; ramREN = granted REN & ~WEN (write wins when both are asserted).
REQ-023 In IDLE, ramREN = ramWEN = 0 and ramaddr = ramstore = 0.
REQ-024 Completion is the GRANT cycle with ramstate==ACCESS. In that cycle rwait[gnt_id]=0 and load[gnt_id]=ramload; the next state is IDLE.
REQ-025 One IDLE cycle always separates two grants; minimum transaction length is 2 cycles.
REQ-026 ramstate BUSY or FREE in GRANT: hold the grant and keep the strobes asserted.
REQ-027 ramstate ERROR in GRANT: hold the grant and re-present the strobes; the requester sees no completion.
REQ-028 Abort: if the granted channel drops both REN and WEN in GRANT before ACCESS, the next state is IDLE and no completion is signalled.
REQ-029 rwait[i] = (REN[i]|WEN[i]) & ~(completion & gnt_id==i).
REQ-030 rwait[i] = 0 for any channel that is not requesting.
REQ-031 load[i] = 0 except in channel i's completion cycle.
REQ-032 Requests arriving while in GRANT are not granted until the next IDLE cycle.
REQ-033 A request that appears in the same cycle as a completion is arbitrated in the following IDLE cycle.

Reset
REQ-034 While RST=1 at an edge: state=IDLE, rr_ptr=0, gnt_id=0, gnt_vld=0.
REQ-035 RST asserted mid-transaction abandons the grant; ramREN/ramWEN are 0 from the cycle after that edge, and no completion is signalled.
REQ-036 After RST deasserts, the first arbitration happens in the first IDLE cycle.

Structure
REQ-037 arb_state_t (IDLE, GRANT) and the MODE encodings belong in cpu_types_pkg; word_t and ramstate_t are reused from that package.
REQ-038 Winner selection is one combinational sub-module, rr_pick, with inputs req[NREQ], ptr and mode, and outputs idx and any.

Verification
REQ-039 Single read: NREQ=4, ch2 REN, addr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> gnt_id=2; rwait[2]=0 and load[2]=0xDEADBEEF on cycle 4; IDLE on cycle 5.
REQ-040 Round-robin fairness: all 4 channels request continuously, RAM always ACCESS -> grant order 0,1,2,3,0 with each completion 2 cycles apart.
REQ-041 Fixed priority: MODE=1, ch1 and ch3 request continuously -> ch1 is always granted and ch3 rwait stays 1.
REQ-042 Write-wins and ERROR retry: ch0 REN=WEN=1, addr=0x80, store=0x1234; ramstate ERROR for 1 cycle then ACCESS -> ramWEN=1 and ramREN=0 throughout; completion on the ACCESS cycle only.
REQ-043 Abort: ch3 drops REN while ramstate=BUSY -> next cycle IDLE, ramREN=0, and rr_ptr unchanged.
REQ-044 Reset mid-transaction: RST=1 during GRANT -> gnt_vld=0 and ramREN/ramWEN=0 after the edge; post-reset arbitration starts from ch0.
